// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter that shares one FIFO write port among N producers.
// Grants bounded bursts, stalls on FIFO full and rotates priority after each release.
module fifo_wr_arbiter #(
  parameter  int N     = 4,
  parameter  int DW    = 32,
  parameter  int BURST = 4,
  localparam int IW    = $clog2(N),
  localparam int CW    = $clog2(BURST + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic [N*DW-1:0] req_data,
  output logic [N-1:0]    gnt,
  output logic [N-1:0]    ack,
  output logic [IW-1:0]   grant_id,
  output logic            busy,
  input  logic            fifo_full,
  output logic            fifo_wr,
  output logic [DW-1:0]   fifo_data
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_e;

  state_e        state_q, state_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [IW-1:0] grant_id_q, grant_id_d;
  logic [IW-1:0] last_q, last_d;
  logic          busy_q, busy_d;
  logic [CW-1:0] beat_cnt_q, beat_cnt_d;

  logic          owner_req;
  logic [DW-1:0] owner_data;
  logic          beat;
  logic          pick_valid;
  logic [IW-1:0] pick_id;
  int            pick_dist;
  int            cand_dist;

  always_comb begin
    owner_req  = 1'b0;
    owner_data = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_id_q == IW'(i)) begin
        owner_req  = req[i];
        owner_data = req_data[i*DW +: DW];
      end
    end
  end

  // Distance 0 is the requester just after the previous owner, N-1 is the previous owner itself.
  always_comb begin
    pick_valid = 1'b0;
    pick_id    = '0;
    pick_dist  = N;
    cand_dist  = 0;
    for (int i = 0; i < N; i++) begin
      cand_dist = (i + N - 1 - int'(last_q)) % N;
      if (req[i] && (cand_dist < pick_dist)) begin
        pick_valid = 1'b1;
        pick_id    = IW'(i);
        pick_dist  = cand_dist;
      end
    end
  end

  assign beat      = (state_q == GRANT) && owner_req && !fifo_full;
  assign fifo_wr   = beat;
  assign ack       = beat ? gnt_q : '0;
  assign fifo_data = (state_q == GRANT) ? owner_data : '0;
  assign gnt       = gnt_q;
  assign grant_id  = grant_id_q;
  assign busy      = busy_q;

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    grant_id_d = grant_id_q;
    last_d     = last_q;
    busy_d     = busy_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d    = GRANT;
          busy_d     = 1'b1;
          grant_id_d = pick_id;
          beat_cnt_d = '0;
          for (int i = 0; i < N; i++) begin
            gnt_d[i] = (pick_id == IW'(i));
          end
        end
      end
      GRANT: begin
        // A dropped request releases with no write; the last beat of a burst releases after its write.
        if (!owner_req || (beat && (beat_cnt_q == CW'(BURST - 1)))) begin
          state_d = IDLE;
          gnt_d   = '0;
          busy_d  = 1'b0;
          last_d  = grant_id_q;
        end else if (beat) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      grant_id_q <= '0;
      last_q     <= IW'(N - 1);
      busy_q     <= 1'b0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      grant_id_q <= grant_id_d;
      last_q     <= last_d;
      busy_q     <= busy_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-side arbiter that shares one synchronous FIFO's write port between N producers. Each producer raises a request. The arbiter grants one producer at a time for a bounded burst of words and forwards that producer's data to the FIFO. It stalls on FIFO full and rotates priority after every burst. It sits directly in front of the FIFO's `wr`/`data_in`/`full` pins.

## Interface
Parameters:
- `N`, 4: number of requesters (2..16).
- `DW`, 32: data width; matches the FIFO `data_in` width.
- `BURST`, 4: maximum words per grant (1..256).

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-low reset; release is synchronous to `clk`.
- `req`  in  N  per-requester request; requester i holds `req[i]` high while it has a valid word on its data slice.
- `req_data`  in  N*DW  packed data; requester i occupies bits [i*DW +: DW].
- `gnt`  out  N  registered one-hot grant (all zero when idle).
- `ack`  out  N  combinational; `ack[i]` is high in any cycle where requester i's word is written to the FIFO.
- `grant_id`  out  clog2(N)  registered index of the current owner; valid while `busy`.
- `busy`  out  1  registered; high in the GRANT state.
- `fifo_full`  in  1  FIFO full flag.
- `fifo_wr`  out  1  combinational FIFO write strobe.
- `fifo_data`  out  DW  combinational; the owner's `req_data` slice, zero when idle.

## Operation
- FSM has two states, IDLE and GRANT. Reset enters IDLE.
- IDLE:
  - If any `req` is high, select the first requester with `req` high, searching `last+1, last+2, … , last` modulo N.
  - Register `gnt` one-hot, set `grant_id`, clear `beat_cnt`, and go to GRANT.
  - If no request is high, stay in IDLE.
- GRANT:
  - A beat occurs when `req[owner]` is high and `fifo_full` is low. In a beat cycle, `fifo_wr` = 1 and `ack[owner]` = 1.
  - If `req[owner]` is high and `fifo_full` is high: stall. No write, `beat_cnt` holds, grant holds. There is no timeout.
  - If `req[owner]` is low: release immediately, with no write that cycle.
  - If a beat occurs with `beat_cnt == BURST-1`: release after that write.
  - Otherwise, a beat increments `beat_cnt`.
- Release: `last` <= owner, `gnt` <= 0, `busy` <= 0, and go to IDLE.
- Outside GRANT, `fifo_wr`, `ack` and `fifo_data` are all 0.
- `fifo_wr` never asserts while `fifo_full` is high. The FIFO never sees a write-on-full from this block.
- `beat_cnt` width is clog2(BURST+1). It never wraps, because release happens at BURST-1.
- `last` wraps modulo N. `last` = N-1 after reset, so requester 0 has first priority.
- Requests from non-owners are ignored during GRANT and are considered only at the next IDLE cycle.
- Reset asserted mid-burst:
  - All state clears immediately and asynchronously: IDLE, `gnt` = 0, `busy` = 0, `grant_id` = 0, `beat_cnt` = 0, `last` = N-1.
  - `fifo_wr`, `fifo_data` and `ack` go to 0 in the same instant.
  - The word in flight is not written.

## Timing
- `req[i]` rising in an IDLE cycle t causes `gnt[i]` and `busy` to be high from cycle t+1. The first possible beat is in cycle t+1.
- Beats are back-to-back at one word per cycle while the owner requests and the FIFO is not full.
- A full burst with no stalls occupies BURST GRANT cycles plus one IDLE arbitration cycle. Peak throughput is therefore BURST/(BURST+1).
- A requester must hold its word stable until it sees `ack[i]`. It advances to its next word on the cycle after `ack[i]`.
- `fifo_full` is sampled combinationally in the same cycle as the write decision. It must be the FIFO's registered full flag.

## Test plan
- Single requester, N=4, BURST=4: `req[0]` is high for 6 words starting from reset.
  - Required: beats in cycles 1–4, IDLE in cycle 5, beats in cycles 6–7.
  - `fifo_data` follows the words 0xA0..0xA5 in order.
  - Release after the last word.
- Fairness: all four `req` held high continuously.
  - Grant order is 0,1,2,3,0,…
  - Each grant gets exactly 4 beats with one idle cycle between grants, so 16 writes every 20 cycles.
- Full stall: `fifo_full` high for 3 cycles after beat 2 of requester 1's burst.
  - `fifo_wr` is 0 and `ack` is 0 during the stall.
  - `beat_cnt` holds at 2, and the burst completes with exactly 4 total writes.
- Early drop: requester 2 deasserts `req` after 2 beats.
  - Release occurs in the drop cycle.
  - The next grant goes to requester 3 if it is requesting, otherwise to 0.
- Reset mid-burst: `rst` is pulled low asynchronously during beat 3.
  - `fifo_wr`, `gnt` and `busy` drop to 0 without waiting for a clock edge.
  - After release, requester 0 is granted first even though requester 1 was the previous owner.
